// File: rtl/rf_wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
package rf_wb_arb_pkg;

    typedef logic [31:0] data_t;
    localparam data_t NULL = '0;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        logic      live;
        reg_addr_t rd;
        data_t     data;
    } wb_req_t;

    typedef enum logic [1:0] {EMPTY, PENDING, FORCE} arb_state_t;

endpackage

// File: rtl/wb_req_fifo.sv
// Sync FIFO of MDU writeback requests with a per-entry rd kill port and two rd-match query ports.
module wb_req_fifo
    import rf_wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  wb_req_t                push_req,
    input  logic                   pop,
    input  logic                   kill,
    input  reg_addr_t              kill_rd,
    input  reg_addr_t [1:0]        q_rd,
    output logic      [1:0]        q_hit,
    output wb_req_t                head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign head = mem[rptr];

    // Popped entries are marked dead so the query only sees occupied slots.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i].live <= 1'b0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill && mem[i].live && mem[i].rd == kill_rd) mem[i].live <= 1'b0;
            if (pop) begin
                mem[rptr].live <= 1'b0;
                rptr           <= rptr + AW'(1);
            end
            if (push) begin
                mem[wptr] <= push_req;
                wptr      <= wptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        q_hit = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                if (mem[i].live && mem[i].rd == q_rd[k]) q_hit[k] = 1'b1;
    end

endmodule

// File: rtl/rf_wb_arb.sv
// Arbitrates the single register-file write port between the writeback stage and queued MDU results.
module rf_wb_arb
    import rf_wb_arb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      pipe_wen,
    input  reg_addr_t pipe_rd,
    input  data_t     pipe_data,
    input  logic      mdu_valid,
    input  reg_addr_t mdu_rd,
    input  data_t     mdu_data,
    output logic      mdu_ready,
    output logic      pipe_stall,
    output logic      rf_wen,
    output reg_addr_t rf_rd,
    output data_t     rf_data,
    input  reg_addr_t chk_rs1,
    input  reg_addr_t chk_rs2,
    output logic      chk_hit
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t    state;
    wb_req_t       head;
    wb_req_t       push_req;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [SW-1:0] starve;
    logic          drain;
    logic          eff;
    logic          head_live;
    logic          pipe_grant;
    logic          pop;
    logic          push;
    logic [1:0]    q_hit;

    wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .kill     (pipe_grant),
        .kill_rd  (pipe_rd),
        .q_rd     ({chk_rs2, chk_rs1}),
        .q_hit    (q_hit),
        .head     (head),
        .count    (count)
    );

    assign eff = pipe_wen && (pipe_rd != '0);

    // Once a forced drain starts it holds until the queue is empty.
    always_comb begin
        state = PENDING;
        if (count == '0)
            state = EMPTY;
        else if (count == CW'(DEPTH) || starve == SW'(STARVE_MAX) || drain)
            state = FORCE;
    end

    // A dead head never needs the port, so it cannot stall the pipe even in FORCE.
    assign head_live  = (count != '0) && head.live;
    assign pipe_grant = eff && !(state == FORCE && head_live);
    assign pop        = (count != '0) && (!head_live || !pipe_grant);
    assign pipe_stall = rst_n && eff && !pipe_grant;
    assign mdu_ready  = rst_n && (count < CW'(DEPTH));
    assign push       = mdu_valid && mdu_ready;
    assign count_next = count + CW'(push) - CW'(pop);

    // A same-cycle granted pipe write to the same rd is younger than the incoming MDU result.
    always_comb begin
        push_req.live = (mdu_rd != '0) && !(pipe_grant && mdu_rd == pipe_rd);
        push_req.rd   = mdu_rd;
        push_req.data = mdu_data;
    end

    assign chk_hit = rst_n &&
        (((chk_rs1 != '0) && (q_hit[0] || (mdu_valid && mdu_rd == chk_rs1))) ||
         ((chk_rs2 != '0) && (q_hit[1] || (mdu_valid && mdu_rd == chk_rs2))));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_wen  <= 1'b0;
            rf_rd   <= '0;
            rf_data <= NULL;
            starve  <= '0;
            drain   <= 1'b0;
        end else begin
            rf_wen <= pipe_grant || (pop && head_live);
            if (pipe_grant) begin
                rf_rd   <= pipe_rd;
                rf_data <= pipe_data;
            end else if (pop && head_live) begin
                rf_rd   <= head.rd;
                rf_data <= head.data;
            end
            if (pop || count == '0)
                starve <= '0;
            else if (pipe_grant && head_live && starve != SW'(STARVE_MAX))
                starve <= starve + SW'(1);
            drain <= (state == FORCE) && (count_next != '0);
        end
    end

endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed bench: expected register-file writes go into a scoreboard queue that a monitor drains.
module tb_rf_wb_arb;
    logic        clk;
    logic        rst_n;
    logic        pipe_wen;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        pipe_stall;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        chk_hit;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    rf_wb_arb #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_wen   (pipe_wen),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .mdu_valid  (mdu_valid),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .pipe_stall (pipe_stall),
        .rf_wen     (rf_wen),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_hit    (chk_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of inputs at the falling edge; comb outputs settle 1 ns later.
    task automatic drv(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        @(negedge clk);
        pipe_wen  = pw;
        pipe_rd   = prd;
        pipe_data = pd;
        mdu_valid = mv;
        mdu_rd    = mrd;
        mdu_data  = md;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Monitor: every rf write must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rf_wen === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got x%0d=%h expected no write", rf_rd, rf_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rf_rd !== e.rd || rf_data !== e.data) begin
                        n_fail++;
                        $display("FAIL rf_write: got x%0d=%h expected x%0d=%h", rf_rd, rf_data, e.rd, e.data);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        chk_rs1 = 5'd0;
        chk_rs2 = 5'd0;
        // Reset with activity on the inputs: outputs must stay quiet.
        drv(1'b1, 5'd3, 32'h1, 1'b1, 5'd7, 32'h2);
        chk_rs1 = 5'd7;
        #1;
        check1("reset_mdu_ready", mdu_ready, 1'b0);
        check1("reset_chk_hit", chk_hit, 1'b0);
        drv(1'b1, 5'd3, 32'h1, 1'b1, 5'd7, 32'h2);
        check1("reset_rf_wen", rf_wen, 1'b0);
        check32("reset_rf_rd", 32'(rf_rd), 32'h0);
        check32("reset_rf_data", rf_data, 32'h0);
        chk_rs1 = 5'd0;
        idle();
        rst_n = 1'b1;
        #1;
        check1("ready_after_reset", mdu_ready, 1'b1);

        // Pipe only, then a dropped x0 write.
        drv(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        check1("pipe_stall_rd5", pipe_stall, 1'b0);
        expect_wr(5'd5, 32'hDEAD_BEEF);
        drv(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
        check1("pipe_stall_x0", pipe_stall, 1'b0);
        check1("pipe_lat_n1", rf_wen, 1'b1);
        idle();
        check1("x0_dropped", rf_wen, 1'b0);

        // MDU while idle: x7=42 two cycles later, hazard visible meanwhile.
        chk_rs1 = 5'd7;
        drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'd42);
        check1("mdu_hit_incoming", chk_hit, 1'b1);
        idle();
        check1("mdu_hit_queued", chk_hit, 1'b1);
        check1("mdu_lat_n1", rf_wen, 1'b0);
        expect_wr(5'd7, 32'd42);
        idle();
        check1("mdu_lat_n2", rf_wen, 1'b1);
        check1("mdu_hit_cleared", chk_hit, 1'b0);
        chk_rs1 = 5'd0;
        idle();

        // Full queue: two MDU results fill the queue and force a two-cycle drain.
        drv(1'b1, 5'd20, 32'h100, 1'b1, 5'd10, 32'hA0);
        check1("full_c0_stall", pipe_stall, 1'b0);
        expect_wr(5'd20, 32'h100);
        drv(1'b1, 5'd21, 32'h101, 1'b1, 5'd11, 32'hB0);
        check1("full_c1_stall", pipe_stall, 1'b0);
        check1("full_c1_ready", mdu_ready, 1'b1);
        expect_wr(5'd21, 32'h101);
        drv(1'b1, 5'd22, 32'h102, 1'b0, 5'd0, 32'h0);
        check1("full_c2_stall", pipe_stall, 1'b1);
        check1("full_c2_ready", mdu_ready, 1'b0);
        expect_wr(5'd10, 32'hA0);
        drv(1'b1, 5'd22, 32'h102, 1'b0, 5'd0, 32'h0);
        check1("full_c3_stall", pipe_stall, 1'b1);
        expect_wr(5'd11, 32'hB0);
        drv(1'b1, 5'd22, 32'h102, 1'b0, 5'd0, 32'h0);
        check1("full_c4_stall", pipe_stall, 1'b0);
        check1("full_c4_ready", mdu_ready, 1'b1);
        expect_wr(5'd22, 32'h102);
        idle();
        idle();

        // Starvation: pipe wins four cycles over a queued result, then stalls once.
        drv(1'b1, 5'd1, 32'h200, 1'b1, 5'd12, 32'hC0);
        expect_wr(5'd1, 32'h200);
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, 5'(i + 1), 32'h200 + 32'(i), 1'b0, 5'd0, 32'h0);
            check1($sformatf("starve_win_%0d", i), pipe_stall, 1'b0);
            expect_wr(5'(i + 1), 32'h200 + 32'(i));
        end
        drv(1'b1, 5'd6, 32'h205, 1'b0, 5'd0, 32'h0);
        check1("starve_force_stall", pipe_stall, 1'b1);
        expect_wr(5'd12, 32'hC0);
        drv(1'b1, 5'd6, 32'h205, 1'b0, 5'd0, 32'h0);
        check1("starve_resume", pipe_stall, 1'b0);
        expect_wr(5'd6, 32'h205);
        idle();
        idle();

        // WAW kill: pipe write of x9 kills queued and incoming x9 results.
        drv(1'b1, 5'd1, 32'h300, 1'b1, 5'd9, 32'h99);
        expect_wr(5'd1, 32'h300);
        drv(1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'h77);
        check1("waw_stall", pipe_stall, 1'b0);
        expect_wr(5'd9, 32'h11);
        chk_rs1 = 5'd9;
        idle();
        check1("waw_hit_dead", chk_hit, 1'b0);
        idle();
        check1("waw_dead_pop1", rf_wen, 1'b0);
        idle();
        check1("waw_dead_pop2", rf_wen, 1'b0);
        chk_rs1 = 5'd0;
        idle();

        // Reset mid-drain with two live entries queued.
        drv(1'b1, 5'd3, 32'h400, 1'b1, 5'd13, 32'hD0);
        expect_wr(5'd3, 32'h400);
        drv(1'b1, 5'd4, 32'h401, 1'b1, 5'd14, 32'hE0);
        expect_wr(5'd4, 32'h401);
        drv(1'b1, 5'd15, 32'h999, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        chk_rs1 = 5'd13;
        #1;
        check1("rst_mid_stall", pipe_stall, 1'b0);
        check1("rst_mid_ready", mdu_ready, 1'b0);
        check1("rst_mid_hit", chk_hit, 1'b0);
        idle();
        rst_n = 1'b1;
        #1;
        check1("rst_mid_rf_wen", rf_wen, 1'b0);
        check32("rst_mid_rf_rd", 32'(rf_rd), 32'h0);
        check32("rst_mid_rf_data", rf_data, 32'h0);
        check1("rst_mid_empty_hit", chk_hit, 1'b0);
        check1("rst_mid_empty_ready", mdu_ready, 1'b1);
        for (int i = 0; i < 4; i++) idle();

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: got %0d pending writes expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
